// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780 refresh controller: LCD commands, init
// nibbles, FSM encodings and a delay-width helper.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h28;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  localparam logic [3:0] INIT_NIB3 = 4'h3;
  localparam logic [3:0] INIT_NIB2 = 4'h2;

  // Top-level sequencer states (init chain followed by the refresh loop)
  localparam logic [3:0] S_PWR_WAIT = 4'd0;
  localparam logic [3:0] S_N3A      = 4'd1;
  localparam logic [3:0] S_N3B      = 4'd2;
  localparam logic [3:0] S_N3C      = 4'd3;
  localparam logic [3:0] S_N2       = 4'd4;
  localparam logic [3:0] S_FUNC     = 4'd5;
  localparam logic [3:0] S_ENTRY    = 4'd6;
  localparam logic [3:0] S_DISP     = 4'd7;
  localparam logic [3:0] S_CLR      = 4'd8;
  localparam logic [3:0] S_IDLE     = 4'd9;
  localparam logic [3:0] S_SETADDR  = 4'd10;
  localparam logic [3:0] S_FETCH    = 4'd11;
  localparam logic [3:0] S_CHAR     = 4'd12;

  // Nibble writer phases
  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_SETUP = 3'd1;
  localparam logic [2:0] PH_PULSE = 3'd2;
  localparam logic [2:0] PH_HOLD  = 3'd3;
  localparam logic [2:0] PH_WAIT  = 3'd4;

  function automatic logic [19:0] cyc(input int unsigned n);
    return 20'(n);
  endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Drives one LCD nibble: data/RS setup, registered E pulse, hold, then a
// programmable post-delay before a one-cycle done.
module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int unsigned T_E = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  nibble,
  input  logic        rs,
  input  logic [19:0] post_delay,
  output logic        LCD_E,
  output logic [3:0]  SF_D,
  output logic        LCD_RS,
  output logic        done
);

  logic [2:0]  phase_q, phase_d;
  logic [19:0] cnt_q, cnt_d;
  logic        e_q, e_d;
  logic [3:0]  sf_d_q, sf_d_d;
  logic        rs_q, rs_d;
  logic        done_q, done_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    phase_d = phase_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    sf_d_d  = sf_d_q;
    rs_d    = rs_q;
    done_d  = 1'b0;
    case (phase_q)
      PH_IDLE: if (start) begin
        sf_d_d  = nibble;
        rs_d    = rs;
        cnt_d   = 20'd1;          // two cycles of setup before E rises
        phase_d = PH_SETUP;
      end
      PH_SETUP: if (cnt_q == '0) begin
        e_d     = 1'b1;
        cnt_d   = cyc(T_E) - 20'd1;
        phase_d = PH_PULSE;
      end else cnt_d = cnt_q - 20'd1;
      PH_PULSE: if (cnt_q == '0) begin
        e_d     = 1'b0;
        phase_d = PH_HOLD;
      end else cnt_d = cnt_q - 20'd1;
      PH_HOLD: begin
        cnt_d   = post_delay - 20'd1;
        phase_d = PH_WAIT;
      end
      PH_WAIT: if (cnt_q == '0) begin
        done_d  = 1'b1;
        phase_d = PH_IDLE;
      end else cnt_d = cnt_q - 20'd1;
      default: phase_d = PH_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      sf_d_q  <= '0;
      rs_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      sf_d_q  <= sf_d_d;
      rs_q    <= rs_d;
      done_q  <= done_d;
    end
  end

  assign LCD_E  = e_q;
  assign SF_D   = sf_d_q;
  assign LCD_RS = rs_q;
  assign done   = done_q;

endmodule

// File: rtl/lcd_refresh_controller.sv
// HD44780 4-bit init followed by continuous refresh of 32 characters read
// from the MultiRAM port (0-15 on line 1, 16-31 on line 2).
module lcd_refresh_controller
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERON = 750000,
  parameter int unsigned T_INIT1   = 205000,
  parameter int unsigned T_INIT2   = 5000,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_CLEAR   = 82000,
  parameter int unsigned T_E       = 12,
  parameter int unsigned T_NIB     = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       refresh_en,
  output logic [4:0] MultiRAM_ADD,
  input  logic [7:0] MultiRAM_DOUT,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [3:0] SF_D,
  output logic       init_done,
  output logic       busy,
  output logic       frame_done
);

  logic [3:0]  state_q, state_d;
  logic        pend_q, pend_d;
  logic        lo_q, lo_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  addr_q, addr_d;
  logic [7:0]  char_q, char_d;
  logic [1:0]  fcnt_q, fcnt_d;
  logic [19:0] pwr_cnt_q, pwr_cnt_d;
  logic        init_done_q, init_done_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;

  logic        wr_start, wr_rs, wr_done;
  logic [3:0]  wr_nibble;
  logic [19:0] wr_delay;
  logic        writes, is_byte, byte_rs, step_done;
  logic [7:0]  byte_val;

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    lo_d         = lo_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    char_d       = char_q;
    fcnt_d       = fcnt_q;
    pwr_cnt_d    = pwr_cnt_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    wr_start     = 1'b0;
    wr_nibble    = '0;
    wr_rs        = 1'b0;
    wr_delay     = cyc(T_CMD);
    writes       = 1'b1;
    is_byte      = 1'b1;
    byte_val     = 8'h00;
    byte_rs      = 1'b0;
    step_done    = 1'b0;

    // What the current state puts on the bus
    case (state_q)
      S_N3A:     begin is_byte = 1'b0; wr_nibble = INIT_NIB3; wr_delay = cyc(T_INIT1); end
      S_N3B:     begin is_byte = 1'b0; wr_nibble = INIT_NIB3; wr_delay = cyc(T_INIT2); end
      S_N3C:     begin is_byte = 1'b0; wr_nibble = INIT_NIB3; end
      S_N2:      begin is_byte = 1'b0; wr_nibble = INIT_NIB2; end
      S_FUNC:    byte_val = CMD_FUNC_SET;
      S_ENTRY:   byte_val = CMD_ENTRY;
      S_DISP:    byte_val = CMD_DISP_ON;
      S_CLR:     byte_val = CMD_CLEAR;
      S_SETADDR: byte_val = idx_q[4] ? CMD_LINE2 : CMD_LINE1;
      S_CHAR:    begin byte_val = char_q; byte_rs = 1'b1; end
      default:   writes = 1'b0;
    endcase

    if (writes && is_byte) begin
      wr_rs     = byte_rs;
      wr_nibble = lo_q ? byte_val[3:0] : byte_val[7:4];
      if (!lo_q)                                wr_delay = cyc(T_NIB);
      else if (!byte_rs && byte_val == CMD_CLEAR) wr_delay = cyc(T_CLEAR);
    end

    // One writer transaction per nibble; a byte is two back-to-back nibbles
    if (writes) begin
      if (!pend_q) begin
        wr_start = 1'b1;
        pend_d   = 1'b1;
      end else if (wr_done) begin
        pend_d = 1'b0;
        if (is_byte && !lo_q) lo_d = 1'b1;
        else begin
          lo_d      = 1'b0;
          step_done = 1'b1;
        end
      end
    end

    case (state_q)
      S_PWR_WAIT:
        if (pwr_cnt_q == cyc(T_POWERON) - 20'd1) begin
          wr_start  = 1'b1;
          wr_nibble = INIT_NIB3;
          wr_delay  = cyc(T_INIT1);
          pend_d    = 1'b1;
          state_d   = S_N3A;
        end else pwr_cnt_d = pwr_cnt_q + 20'd1;
      S_N3A:     if (step_done) state_d = S_N3B;
      S_N3B:     if (step_done) state_d = S_N3C;
      S_N3C:     if (step_done) state_d = S_N2;
      S_N2:      if (step_done) state_d = S_FUNC;
      S_FUNC:    if (step_done) state_d = S_ENTRY;
      S_ENTRY:   if (step_done) state_d = S_DISP;
      S_DISP:    if (step_done) state_d = S_CLR;
      S_CLR:     if (step_done) begin init_done_d = 1'b1; state_d = S_IDLE; end
      S_IDLE:    if (refresh_en) state_d = S_SETADDR;
      S_SETADDR: if (step_done) state_d = S_FETCH;
      S_FETCH:
        // Address register, then one cycle of RAM latency, then capture
        case (fcnt_q)
          2'd0:    begin addr_d = idx_q; fcnt_d = 2'd1; end
          2'd1:    fcnt_d = 2'd2;
          default: begin char_d = MultiRAM_DOUT; fcnt_d = 2'd0; state_d = S_CHAR; end
        endcase
      S_CHAR:
        if (step_done) begin
          idx_d = idx_q + 5'd1;
          if (idx_q == 5'd15)      state_d = S_SETADDR;
          else if (idx_q == 5'd31) begin frame_done_d = 1'b1; state_d = S_IDLE; end
          else                     state_d = S_FETCH;
        end
      default:   state_d = S_PWR_WAIT;
    endcase

    busy_d = (state_d == S_SETADDR) || (state_d == S_FETCH) || (state_d == S_CHAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_PWR_WAIT;
      pend_q       <= 1'b0;
      lo_q         <= 1'b0;
      idx_q        <= '0;
      addr_q       <= '0;
      char_q       <= '0;
      fcnt_q       <= '0;
      pwr_cnt_q    <= '0;
      init_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      lo_q         <= lo_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      char_q       <= char_d;
      fcnt_q       <= fcnt_d;
      pwr_cnt_q    <= pwr_cnt_d;
      init_done_q  <= init_done_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  lcd_nibble_writer #(.T_E(T_E)) u_writer (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (wr_start),
    .nibble     (wr_nibble),
    .rs         (wr_rs),
    .post_delay (wr_delay),
    .LCD_E      (LCD_E),
    .SF_D       (SF_D),
    .LCD_RS     (LCD_RS),
    .done       (wr_done)
  );

  assign MultiRAM_ADD = addr_q;
  assign LCD_RW       = 1'b0;
  assign init_done    = init_done_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_lcd_refresh_controller.sv
// Directed bench for lcd_refresh_controller with scaled timing: init stream,
// frame contents, refresh_en drop, mid-frame reset and E-strobe timing.
module tb_lcd_refresh_controller;

  localparam int T_POWERON = 100;
  localparam int T_INIT1   = 40;
  localparam int T_INIT2   = 20;
  localparam int T_CMD     = 10;
  localparam int T_CLEAR   = 30;
  localparam int T_E       = 3;
  localparam int T_NIB     = 4;

  localparam logic [3:0] INIT_SEQ [12] =
    '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       refresh_en;
  logic [4:0] MultiRAM_ADD;
  logic [7:0] MultiRAM_DOUT;
  logic       LCD_E, LCD_RS, LCD_RW;
  logic [3:0] SF_D;
  logic       init_done, busy, frame_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [32];
  logic [9:0] cap [$];      // {MultiRAM_ADD, RS, nibble} at each E rise
  int         fd_cnt = 0;

  always #5 clk = ~clk;

  lcd_refresh_controller #(
    .T_POWERON (T_POWERON), .T_INIT1 (T_INIT1), .T_INIT2 (T_INIT2), .T_CMD (T_CMD),
    .T_CLEAR   (T_CLEAR),   .T_E     (T_E),     .T_NIB   (T_NIB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .refresh_en    (refresh_en),
    .MultiRAM_ADD  (MultiRAM_ADD),
    .MultiRAM_DOUT (MultiRAM_DOUT),
    .LCD_E         (LCD_E),
    .LCD_RS        (LCD_RS),
    .LCD_RW        (LCD_RW),
    .SF_D          (SF_D),
    .init_done     (init_done),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  // Synchronous RAM: data appears one clock after the address is sampled
  always @(posedge clk) MultiRAM_DOUT <= ram[MultiRAM_ADD];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // E-strobe monitor: captures nibbles and checks setup, width, hold and gap
  logic       prev_e;
  logic [4:0] hist1, hist2, at_rise;
  int         hi_cnt, gap;
  bit         seen_fall;

  always @(negedge clk) begin
    logic [4:0] cur;
    cur = {LCD_RS, SF_D};
    if (!rst_n) begin
      prev_e = 1'b0; hist1 = '0; hist2 = '0; at_rise = '0;
      hi_cnt = 0; gap = 0; seen_fall = 1'b0;
    end else begin
      if (frame_done) fd_cnt++;
      if (LCD_E && !prev_e) begin
        check("setup_2_before", {hist2, hist1}, {cur, cur});
        if (seen_fall) check("nib_gap_min", 32'(gap >= T_NIB), 1);
        cap.push_back({MultiRAM_ADD, cur});
        at_rise = cur;
        hi_cnt  = 1;
      end else if (LCD_E) begin
        hi_cnt++;
      end else if (prev_e) begin
        check("e_width", 32'(hi_cnt), 32'(T_E));
        check("hold_after_fall", cur, at_rise);
        seen_fall = 1'b1;
        gap = 1;
      end else begin
        gap++;
      end
      prev_e = LCD_E;
      hist2  = hist1;
      hist1  = cur;
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_e"},    LCD_E, 0);
    check({tag, "_rs"},   LCD_RS, 0);
    check({tag, "_rw"},   LCD_RW, 0);
    check({tag, "_sfd"},  SF_D, 0);
    check({tag, "_add"},  MultiRAM_ADD, 0);
    check({tag, "_init"}, init_done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_fd"},   frame_done, 0);
  endtask

  task automatic pop_nib(output logic [9:0] v);
    int n = 0;
    while (cap.size() == 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("nib_avail", 32'(cap.size() > 0), 1);
    v = (cap.size() > 0) ? cap.pop_front() : '0;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] b, input logic rs, input int a);
    logic [9:0] v;
    pop_nib(v);
    check({tag, "_hi"}, v[4:0], {rs, b[7:4]});
    if (a >= 0) check("fetch_addr", v[9:5], a[4:0]);
    pop_nib(v);
    check({tag, "_lo"}, v[4:0], {rs, b[3:0]});
  endtask

  task automatic release_and_init();
    logic [9:0] v;
    int n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cap.delete();
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!LCD_E && n < 1000);
    check("first_e_cycle", n, T_POWERON + 2);
    check("first_e_nib", SF_D, 4'h3);
    check("init_done_early", init_done, 0);
    for (int i = 0; i < 12; i++) begin
      pop_nib(v);
      check("init_nib", v[4:0], {1'b0, INIT_SEQ[i]});
    end
    n = 0;
    while (!init_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("init_done_rise", init_done, 1);
    check("init_done_after_clear", 32'(n >= T_E + T_CLEAR), 1);
  endtask

  task automatic run_frame(input int drop_at, input int rst_at);
    logic [9:0] v;
    expect_byte("line1", 8'h80, 1'b0, -1);
    check("busy_in_frame", busy, 1);
    for (int a = 0; a < 32; a++) begin
      if (a == 16) expect_byte("line2", 8'hC0, 1'b0, -1);
      if (a == rst_at) begin
        pop_nib(v);
        check("char_hi_pre_rst", v[4:0], {1'b1, ram[a][7:4]});
        return;
      end
      expect_byte("char", ram[a], 1'b1, a);
      if (a == drop_at) refresh_en = 1'b0;
    end
  endtask

  task automatic wait_fd(input int target);
    int n = 0;
    while (fd_cnt < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_cnt", fd_cnt, target);
  endtask

  initial begin
    refresh_en = 1'b0;
    rst_n      = 1'b1;
    for (int i = 0; i < 32; i++) ram[i] = 8'(8'h41 + i);
    #2 rst_n = 1'b0;
    #1 check_reset("por");
    repeat (3) @(negedge clk);
    release_and_init();

    // refresh_en low: nothing after init
    repeat (100) @(negedge clk);
    check("quiet_no_e", cap.size(), 0);
    check("idle_busy", busy, 0);

    refresh_en = 1'b1;
    run_frame(-1, -1);
    // Non-printable and high codes must pass through unmodified
    for (int i = 0; i < 32; i++) ram[i] = 8'((i * 29) ^ 8'h93);
    wait_fd(1);

    run_frame(5, -1);
    wait_fd(2);
    repeat (200) @(negedge clk);
    check("drop_no_e", cap.size(), 0);
    check("drop_busy", busy, 0);
    check("drop_e_low", LCD_E, 0);
    check("fd_once_per_frame", fd_cnt, 2);

    refresh_en = 1'b1;
    run_frame(-1, 20);
    #2 rst_n = 1'b0;
    #1 check_reset("mid_rst");
    repeat (3) @(negedge clk);
    check_reset("rst_held");
    release_and_init();
    run_frame(-1, -1);
    wait_fd(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
